// File: rtl/fft_frame_sequencer_pkg.sv
// rtl/fft_frame_sequencer_pkg.sv - shared constants and state type for the FFT frame sequencer
package fft_seq_pkg;
  localparam int N_POINTS  = 512;
  localparam int LANES     = 16;
  localparam int BEATS     = N_POINTS / LANES;
  localparam int ROM_DEPTH = 32;
  localparam int ROM_AW    = $clog2(ROM_DEPTH);
  // One bit wider than a beat index so a finished count is distinguishable from the last beat
  localparam int CNT_W     = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {IDLE, FEED, WAIT_OUT, GAP} seq_state_t;
endpackage

// File: rtl/fft_frame_sequencer_if.sv
// rtl/fft_frame_sequencer_if.sv - ROM/FFT-side signals of the frame sequencer
interface fft_frame_sequencer_if;
  import fft_seq_pkg::*;

  logic [ROM_AW-1:0] rom_addr;
  logic              rom_en;
  logic              din_en;
  logic              do_en;

  modport master (output rom_addr, output rom_en, output din_en, input do_en);
  modport slave  (input rom_addr, input rom_en, input din_en, output do_en);
endinterface

// File: rtl/fft_frame_sequencer_beat_counter.sv
// rtl/fft_frame_sequencer_beat_counter.sv - beat counter saturating at TC; tc pulses on the TC-th inc
module fft_beat_counter #(
  parameter int W  = 6,
  parameter int TC = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc
);
  localparam logic [W-1:0] TC_V   = W'(TC);
  localparam logic [W-1:0] LAST_V = W'(TC - 1);

  logic [W-1:0] cnt_q;

  assign count = cnt_q;
  assign tc    = inc && (cnt_q == LAST_V);

  // Holding at TC makes any further inc a no-op until the next clr
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != TC_V)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end
endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - feeds ROM beats into the FFT and counts its output bursts
// Optional watchdog on the output burst is built when FFT_SEQ_TMO_EN is defined.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int GAP_CYC = 4,
  parameter int TMO_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  run,
  fft_frame_sequencer_if.master fft,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  err_tmo
);
  localparam int                GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0]  BEATS_V   = CNT_W'(BEATS);
  localparam logic [ROM_AW-1:0] ADDR_LAST = ROM_AW'(BEATS - 1);

  seq_state_t       state_q, state_d, post_frame;
  logic [CNT_W-1:0] addr_cnt, out_cnt;
  logic             addr_inc, addr_tc, out_inc, out_tc, out_done;
  logic             enter_feed, tmo_fire;
  logic [GAP_W-1:0] gap_q;
  logic [15:0]      frame_cnt_q;
  logic             din_en_q;

  assign addr_inc = (state_q == FEED);
  assign out_inc  = fft.do_en && ((state_q == FEED) || (state_q == WAIT_OUT));
  assign out_done = (out_cnt == BEATS_V) || out_tc;

  fft_beat_counter #(.W(CNT_W), .TC(BEATS)) u_addr_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (enter_feed),
    .inc   (addr_inc),
    .count (addr_cnt),
    .tc    (addr_tc)
  );

  fft_beat_counter #(.W(CNT_W), .TC(BEATS)) u_out_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (enter_feed),
    .inc   (out_inc),
    .count (out_cnt),
    .tc    (out_tc)
  );

  always_comb begin
    if (GAP_CYC > 0) begin
      post_frame = GAP;
    end else if (run) begin
      post_frame = FEED;
    end else begin
      post_frame = IDLE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (run) state_d = FEED;
      // Output may finish while still feeding when the FFT overlaps frames
      FEED:     if (addr_tc) state_d = out_done ? post_frame : WAIT_OUT;
      WAIT_OUT: begin
        if (out_tc) begin
          state_d = post_frame;
        end else if (tmo_fire) begin
          state_d = IDLE;
        end
      end
      GAP:      if (gap_q == GAP_LAST) state_d = run ? FEED : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign enter_feed = (state_d == FEED) && ((state_q != FEED) || addr_tc);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      frame_cnt_q <= '0;
      din_en_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      din_en_q <= (state_q == FEED);
      if (state_q == GAP) begin
        gap_q <= gap_q + GAP_W'(1);
      end else begin
        gap_q <= '0;
      end
      if (out_tc) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // The address counter parks at BEATS after a feed; report the last beat address then
  assign fft.rom_addr = addr_cnt[CNT_W-1] ? ADDR_LAST : addr_cnt[ROM_AW-1:0];
  assign fft.rom_en   = (state_q == FEED);
  assign fft.din_en   = din_en_q;
  assign busy         = (state_q != IDLE);
  assign frame_done   = out_tc;
  assign frame_cnt    = frame_cnt_q;

`ifdef FFT_SEQ_TMO_EN
  // Expires so that err_tmo is visible TMO_CYC cycles after the last input beat
  localparam logic [9:0] WD_LAST = 10'(TMO_CYC - 2);

  logic [9:0] wd_q;
  logic       err_q;

  assign tmo_fire = (state_q == WAIT_OUT) && (wd_q == WD_LAST) && !out_tc;
  assign err_tmo  = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == WAIT_OUT) begin
        wd_q <= wd_q + 10'd1;
      end else begin
        wd_q <= '0;
      end
      if (tmo_fire) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign err_tmo  = 1'b0;
`endif
endmodule
